// File: rtl/xnor_match_pkg.sv
// Shared definitions for the bit-serial frame comparator: controller states
// and counter sizing.
package xnor_match_pkg;

    localparam int CW        = 4;
    localparam int WIDTH_MAX = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/xnor1.sv
// Single-bit equality cell: y is 1 when a and b carry the same value.
module xnor1 (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = ~(a ^ b);

endmodule

// File: rtl/xnor_match_ctrl.sv
// Frame comparator controller: feeds strobed bit pairs through xnor1, counts
// equal pairs over a WIDTH-pair frame and reports the frame result.
module xnor_match_ctrl
    import xnor_match_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          valid,
    input  logic          a_in,
    input  logic          b_in,
    output logic          done,
    output logic          match,
    output logic          busy,
    output logic [CW-1:0] eq_count
);

    localparam logic [CW-1:0] ZERO       = '0;
    localparam logic [CW-1:0] ONE        = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] LAST_INDEX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] WIDTH_CW   = CW'(WIDTH);

    state_t        state_reg, state_next;
    logic [CW-1:0] count_reg, count_next;
    logic [CW-1:0] index_reg, index_next;
    logic [CW-1:0] eq_count_reg, eq_count_next;
    logic          match_reg, match_next;
    logic          done_reg;
    logic          busy_reg;
    logic          eq_bit;
    logic [CW-1:0] count_sum;

    xnor1 u_xnor1 (
        .a (a_in),
        .b (b_in),
        .y (eq_bit)
    );

    assign count_sum = count_reg + {{(CW-1){1'b0}}, eq_bit};

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        index_next    = index_reg;
        eq_count_next = eq_count_reg;
        match_next    = match_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    count_next = ZERO;
                    index_next = ZERO;
                end
            end
            RUN: begin
                // A restart request discards any pair presented in the same cycle.
                if (start) begin
                    count_next = ZERO;
                    index_next = ZERO;
                end else if (valid) begin
                    count_next = count_sum;
                    index_next = index_reg + ONE;
                    if (index_reg == LAST_INDEX) begin
                        state_next    = DONE;
                        eq_count_next = count_sum;
                        match_next    = (count_sum == WIDTH_CW);
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_next = RUN;
                    count_next = ZERO;
                    index_next = ZERO;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            count_reg    <= ZERO;
            index_reg    <= ZERO;
            eq_count_reg <= ZERO;
            match_reg    <= 1'b0;
            done_reg     <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            index_reg    <= index_next;
            eq_count_reg <= eq_count_next;
            match_reg    <= match_next;
            done_reg     <= (state_next == DONE);
            busy_reg     <= (state_next == RUN);
        end
    end

    assign done     = done_reg;
    assign match    = match_reg;
    assign busy     = busy_reg;
    assign eq_count = eq_count_reg;

endmodule

// File: tb/tb_xnor_match_ctrl.sv
// Directed bench for xnor_match_ctrl: hand-computed frame results, cycle-exact
// done/busy timing, abort, reset and back-to-back behaviour.
module tb_xnor_match_ctrl;
    import xnor_match_pkg::*;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          valid = 1'b0;
    logic          a_in  = 1'b0;
    logic          b_in  = 1'b0;
    logic          done;
    logic          match;
    logic          busy;
    logic [CW-1:0] eq_count;

    int vectors     = 0;
    int miscompares = 0;

    xnor_match_ctrl #(.WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .valid    (valid),
        .a_in     (a_in),
        .b_in     (b_in),
        .done     (done),
        .match    (match),
        .busy     (busy),
        .eq_count (eq_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic exp_done, input logic exp_busy,
                                 input logic [3:0] exp_eq, input logic exp_match);
        check({tag, ".done"},     {3'b000, done},  {3'b000, exp_done});
        check({tag, ".busy"},     {3'b000, busy},  {3'b000, exp_busy});
        check({tag, ".eq_count"}, eq_count,        exp_eq);
        check({tag, ".match"},    {3'b000, match}, {3'b000, exp_match});
    endtask

    // Call right after the start edge; returns in the cycle done must be high.
    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input bit gapped,
                              input logic [3:0] prev_eq, input logic prev_match,
                              input logic [3:0] exp_eq, input logic exp_match,
                              input string tag);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (gapped && i > 0) begin
                valid = 1'b0;
                a_in  = 1'b1;
                b_in  = 1'b0;
                tick();
                check_outputs({tag, "_gap"}, 1'b0, 1'b1, prev_eq, prev_match);
            end
            valid = 1'b1;
            a_in  = a[i];
            b_in  = b[i];
            tick();
            if (i < 7)
                check_outputs({tag, "_run"}, 1'b0, 1'b1, prev_eq, prev_match);
        end
        valid = 1'b0;
        check_outputs({tag, "_end"}, 1'b1, 1'b0, exp_eq, exp_match);
        $display("frame %s: a=%02h b=%02h eq_count=%0d match=%0d", tag, a, b, eq_count, match);
    endtask

    initial begin
        // Reset values
        #12;
        check_outputs("reset", 1'b0, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Equal frame, continuous valid: done in cycle 9 after start
        start = 1'b1;
        tick();
        check_outputs("eq_start", 1'b0, 1'b1, 4'd0, 1'b0);
        send_frame(8'hA5, 8'hA5, 1'b0, 4'd0, 1'b0, 4'd8, 1'b1, "eq");
        tick();
        check_outputs("eq_after", 1'b0, 1'b0, 4'd8, 1'b1);

        // Gapped valid: done in cycle 16, ignored pairs are mismatching
        start = 1'b1;
        tick();
        check_outputs("gap_start", 1'b0, 1'b1, 4'd8, 1'b1);
        send_frame(8'hA5, 8'hA5, 1'b1, 4'd8, 1'b1, 4'd8, 1'b1, "gap");
        tick();
        check_outputs("gap_after", 1'b0, 1'b0, 4'd8, 1'b1);

        // Mismatch frame: upper nibble differs
        start = 1'b1;
        tick();
        send_frame(8'hFF, 8'h0F, 1'b0, 4'd8, 1'b1, 4'd4, 1'b0, "mis");
        tick();
        check_outputs("mis_after", 1'b0, 1'b0, 4'd4, 1'b0);

        // Reset mid-frame after 3 pairs
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1;
            a_in  = 1'b1;
            b_in  = 1'b1;
            tick();
        end
        check_outputs("pre_rst", 1'b0, 1'b1, 4'd4, 1'b0);
        reset = 1'b0;
        #1;
        check_outputs("rst_mid", 1'b0, 1'b0, 4'd0, 1'b0);
        start = 1'b1;
        tick();
        check_outputs("rst_hold", 1'b0, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        valid = 1'b0;
        tick();
        check_outputs("rst_start", 1'b0, 1'b1, 4'd0, 1'b0);
        send_frame(8'h3C, 8'h3C, 1'b0, 4'd0, 1'b0, 4'd8, 1'b1, "post_rst");
        tick();

        // Abort after 5 equal pairs; pair in the restart cycle is discarded
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1;
            a_in  = 1'b1;
            b_in  = 1'b1;
            tick();
            check_outputs("abort_pre", 1'b0, 1'b1, 4'd8, 1'b1);
        end
        start = 1'b1;
        valid = 1'b1;
        tick();
        check_outputs("abort_restart", 1'b0, 1'b1, 4'd8, 1'b1);
        send_frame(8'h96, 8'h96, 1'b0, 4'd8, 1'b1, 4'd8, 1'b1, "abort");
        start = 1'b0;
        tick();

        // Valid in IDLE is ignored
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1;
            a_in  = 1'b0;
            b_in  = 1'b1;
            tick();
            check_outputs("idle_valid", 1'b0, 1'b0, 4'd8, 1'b1);
        end

        // Start with valid in IDLE drops the pair; then back-to-back frames
        start = 1'b1;
        valid = 1'b1;
        tick();
        check_outputs("b2b_start", 1'b0, 1'b1, 4'd8, 1'b1);
        send_frame(8'hFF, 8'h0F, 1'b0, 4'd8, 1'b1, 4'd4, 1'b0, "b2b_first");
        start = 1'b1;
        tick();
        check_outputs("b2b_restart", 1'b0, 1'b1, 4'd4, 1'b0);
        send_frame(8'h5A, 8'h5A, 1'b0, 4'd4, 1'b0, 4'd8, 1'b1, "b2b_second");
        start = 1'b0;
        tick();
        check_outputs("b2b_after", 1'b0, 1'b0, 4'd8, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
